// File: rtl/alu_exec_pkg.sv
// Shared decode constants for the LEGv8 ALU execute unit: opcodes, ALU-op
// encodings, internal control codes and NZCV bit positions.
package alu_exec_pkg;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_PASSB  = 2'b01;
  localparam logic [1:0] ALU_OP_DECODE = 2'b10;
  localparam logic [1:0] ALU_OP_RSVD   = 2'b11;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_ADDS = 11'b10101011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_SUBS = 11'b11101011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ANDS = 11'b11101010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_EOR  = 11'b11001010000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [10:0] OPC_MUL  = 11'b10011011000;

  localparam logic [3:0] CTL_AND   = 4'b0000;
  localparam logic [3:0] CTL_ORR   = 4'b0001;
  localparam logic [3:0] CTL_ADD   = 4'b0010;
  localparam logic [3:0] CTL_EOR   = 4'b0011;
  localparam logic [3:0] CTL_LSL   = 4'b0100;
  localparam logic [3:0] CTL_LSR   = 4'b0101;
  localparam logic [3:0] CTL_SUB   = 4'b0110;
  localparam logic [3:0] CTL_PASSB = 4'b0111;
  localparam logic [3:0] CTL_MUL   = 4'b1000;

  typedef enum logic [1:0] {
    NZCV_V = 2'd0,
    NZCV_C = 2'd1,
    NZCV_Z = 2'd2,
    NZCV_N = 2'd3
  } nzcv_idx_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
// done is high in the last busy cycle, with product already final.
module alu_mul_iter #(
  parameter int DATA_W   = 64,
  parameter int MUL_BITS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int STEPS = DATA_W / MUL_BITS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] partial;

  // Only the low DATA_W bits of the product are kept, so the shifted
  // multiplicand may drop its upper bits freely.
  assign partial = a_q * DATA_W'(b_q[MUL_BITS-1:0]);
  assign product = acc_q + partial;
  assign done    = busy && (cnt_q == CNT_W'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy  <= 1'b0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (start && !busy) begin
      busy  <= 1'b1;
      cnt_q <= '0;
      a_q   <= a;
      b_q   <= b;
      acc_q <= '0;
    end else if (busy) begin
      acc_q <= product;
      a_q   <= a_q << MUL_BITS;
      b_q   <= b_q >> MUL_BITS;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// LEGv8 EX stage: ALU-op/opcode decode, registered single-cycle execute,
// iterative MUL and a persistent NZCV flag register.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int MUL_BITS = 1,
  parameter int SHAMT_W  = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [10:0]        opcode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  op_a,
  input  logic [DATA_W-1:0]  op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic               out_zero,
  output logic               out_illegal,
  output logic [3:0]         flags_nzcv,
  output logic               busy
);

  localparam int MSB = DATA_W - 1;

  logic [3:0]        ctl;
  logic              illegal;
  logic              set_flags;
  logic [DATA_W:0]   add_full;
  logic [DATA_W:0]   sub_full;
  logic [DATA_W-1:0] exe_result;
  logic              exe_c;
  logic              exe_v;
  logic              accept;
  logic              is_mul;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  // Handshake: a transfer happens on any rising edge where valid && ready.
  // Input side is ready when no MUL is running and the result slot is empty
  // or being drained in the same cycle; the output holds until consumed.
  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (ctl == CTL_MUL) && !illegal;
  assign out_zero = (out_result == '0);

  always_comb begin
    ctl       = CTL_AND;
    illegal   = 1'b0;
    set_flags = 1'b0;
    case (alu_op)
      ALU_OP_ADD:    ctl = CTL_ADD;
      ALU_OP_PASSB:  ctl = CTL_PASSB;
      ALU_OP_DECODE: begin
        case (opcode)
          OPC_ADD:  ctl = CTL_ADD;
          OPC_ADDS: begin ctl = CTL_ADD; set_flags = 1'b1; end
          OPC_SUB:  ctl = CTL_SUB;
          OPC_SUBS: begin ctl = CTL_SUB; set_flags = 1'b1; end
          OPC_AND:  ctl = CTL_AND;
          OPC_ANDS: begin ctl = CTL_AND; set_flags = 1'b1; end
          OPC_ORR:  ctl = CTL_ORR;
          OPC_EOR:  ctl = CTL_EOR;
          OPC_LSL:  ctl = CTL_LSL;
          OPC_LSR:  ctl = CTL_LSR;
          OPC_MUL:  ctl = CTL_MUL;
          default:  illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  assign sub_full = {1'b0, op_a} + {1'b0, ~op_b} + (DATA_W+1)'(1);

  always_comb begin
    exe_result = '0;
    exe_c      = 1'b0;
    exe_v      = 1'b0;
    case (ctl)
      CTL_ADD: begin
        exe_result = add_full[MSB:0];
        exe_c      = add_full[DATA_W];
        exe_v      = (op_a[MSB] == op_b[MSB]) && (add_full[MSB] != op_a[MSB]);
      end
      CTL_SUB: begin
        exe_result = sub_full[MSB:0];
        exe_c      = sub_full[DATA_W];
        exe_v      = (op_a[MSB] != op_b[MSB]) && (sub_full[MSB] != op_a[MSB]);
      end
      CTL_AND:   exe_result = op_a & op_b;
      CTL_ORR:   exe_result = op_a | op_b;
      CTL_EOR:   exe_result = op_a ^ op_b;
      CTL_LSL:   exe_result = op_a << shamt;
      CTL_LSR:   exe_result = op_a >> shamt;
      CTL_PASSB: exe_result = op_b;
      default:   exe_result = '0;
    endcase
    if (illegal) exe_result = '0;
  end

  alu_mul_iter #(
    .DATA_W  (DATA_W),
    .MUL_BITS(MUL_BITS)
  ) u_mul (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (accept && is_mul),
    .a      (op_a),
    .b      (op_b),
    .busy   (busy),
    .done   (mul_done),
    .product(mul_product)
  );

  // No accept can coincide with mul_done because in_ready is low while busy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_illegal <= 1'b0;
      flags_nzcv  <= '0;
    end else if (mul_done) begin
      out_valid   <= 1'b1;
      out_result  <= mul_product;
      out_illegal <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid   <= 1'b1;
      out_result  <= exe_result;
      out_illegal <= illegal;
      if (set_flags && !illegal) begin
        flags_nzcv[NZCV_N] <= exe_result[MSB];
        flags_nzcv[NZCV_Z] <= (exe_result == '0);
        flags_nzcv[NZCV_C] <= exe_c;
        flags_nzcv[NZCV_V] <= exe_v;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed checks pinned to literal values plus a
// randomized run compared every cycle against an operation-level model.
module tb_alu_exec_unit;

  localparam int DW    = 64;
  localparam int MUL_N = 64;

  localparam logic [10:0] O_ADD  = 11'b10001011000;
  localparam logic [10:0] O_ADDS = 11'b10101011000;
  localparam logic [10:0] O_SUB  = 11'b11001011000;
  localparam logic [10:0] O_SUBS = 11'b11101011000;
  localparam logic [10:0] O_AND  = 11'b10001010000;
  localparam logic [10:0] O_ANDS = 11'b11101010000;
  localparam logic [10:0] O_ORR  = 11'b10101010000;
  localparam logic [10:0] O_EOR  = 11'b11001010000;
  localparam logic [10:0] O_LSL  = 11'b11010011011;
  localparam logic [10:0] O_LSR  = 11'b11010011010;
  localparam logic [10:0] O_MUL  = 11'b10011011000;
  localparam logic [10:0] OPC_TAB [11] = '{O_ADD, O_ADDS, O_SUB, O_SUBS, O_AND,
                                           O_ANDS, O_ORR, O_EOR, O_LSL, O_LSR, O_MUL};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic          in_valid, in_ready, out_valid, out_ready, out_zero, out_illegal, busy;
  logic [1:0]    alu_op;
  logic [10:0]   opcode;
  logic [5:0]    shamt;
  logic [DW-1:0] op_a, op_b, out_result;
  logic [3:0]    flags_nzcv;

  logic          q4_in_valid, q4_in_ready, q4_out_valid, q4_out_ready, q4_out_zero;
  logic          q4_out_illegal, q4_busy;
  logic [1:0]    q4_alu_op;
  logic [10:0]   q4_opcode;
  logic [5:0]    q4_shamt;
  logic [DW-1:0] q4_op_a, q4_op_b, q4_out_result;
  logic [3:0]    q4_flags_nzcv;

  alu_exec_unit #(.DATA_W(DW), .MUL_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .opcode(opcode), .shamt(shamt), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal), .flags_nzcv(flags_nzcv),
    .busy(busy)
  );

  alu_exec_unit #(.DATA_W(DW), .MUL_BITS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(q4_in_valid), .in_ready(q4_in_ready),
    .alu_op(q4_alu_op), .opcode(q4_opcode), .shamt(q4_shamt), .op_a(q4_op_a),
    .op_b(q4_op_b), .out_valid(q4_out_valid), .out_ready(q4_out_ready),
    .out_result(q4_out_result), .out_zero(q4_out_zero), .out_illegal(q4_out_illegal),
    .flags_nzcv(q4_flags_nzcv), .busy(q4_busy)
  );

  int checks   = 0;
  int failures = 0;
  logic cmp_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics of one operation, straight from the arithmetic rules.
  function automatic void ref_exec(input logic [1:0] aop, input logic [10:0] opc,
                                   input logic [5:0] sh, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, output logic [DW-1:0] res,
                                   output logic ill, output logic mul,
                                   output logic setf, output logic [3:0] nz);
    logic c, v;
    logic [DW:0] u;
    logic signed [DW:0] ws;
    res = '0; ill = 1'b0; mul = 1'b0; setf = 1'b0; c = 1'b0; v = 1'b0;
    if (aop == 2'b00) res = a + b;
    else if (aop == 2'b01) res = b;
    else if (aop == 2'b11) ill = 1'b1;
    else begin
      case (opc)
        O_ADD, O_ADDS: begin
          u = {1'b0, a} + {1'b0, b};
          res = u[DW-1:0]; c = u[DW];
          ws = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
          v = ws[DW] != ws[DW-1];
          setf = (opc == O_ADDS);
        end
        O_SUB, O_SUBS: begin
          res = a - b; c = (a >= b);
          ws = $signed({a[DW-1], a}) - $signed({b[DW-1], b});
          v = ws[DW] != ws[DW-1];
          setf = (opc == O_SUBS);
        end
        O_AND, O_ANDS: begin res = a & b; setf = (opc == O_ANDS); end
        O_ORR: res = a | b;
        O_EOR: res = a ^ b;
        O_LSL: res = a << sh;
        O_LSR: res = a >> sh;
        O_MUL: mul = 1'b1;
        default: ill = 1'b1;
      endcase
    end
    nz = {res[DW-1], res == '0, c, v};
  endfunction

  // Behavioural model: result slot, flags and a MUL countdown.
  logic          m_valid = 1'b0, m_illegal = 1'b0;
  logic [DW-1:0] m_result = '0, m_ma = '0, m_mb = '0;
  logic [3:0]    m_flags = '0;
  int            m_cnt = 0;

  always @(posedge clk) begin : model
    logic rdy, acc, cons, ill, mul, setf;
    logic [DW-1:0] res;
    logic [3:0] nz;
    if (!reset_n) begin
      m_valid = 1'b0; m_illegal = 1'b0; m_result = '0; m_flags = '0; m_cnt = 0;
    end else begin
      rdy  = (m_cnt == 0) && (!m_valid || out_ready);
      acc  = in_valid && rdy;
      cons = m_valid && out_ready;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_result = m_ma * m_mb; m_valid = 1'b1; m_illegal = 1'b0;
        end
      end else if (acc) begin
        ref_exec(alu_op, opcode, shamt, op_a, op_b, res, ill, mul, setf, nz);
        if (mul) begin
          m_cnt = MUL_N; m_ma = op_a; m_mb = op_b;
          if (cons) m_valid = 1'b0;
        end else begin
          m_result = res; m_illegal = ill; m_valid = 1'b1;
          if (setf && !ill) m_flags = nz;
        end
      end else if (cons) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle compare, after any input changes made at the falling edge.
  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      check("cmp_out_valid", out_valid, m_valid);
      check("cmp_busy", busy, m_cnt > 0);
      check("cmp_in_ready", in_ready, (m_cnt == 0) && (!m_valid || out_ready));
      check("cmp_flags", flags_nzcv, m_flags);
      if (m_valid) begin
        check("cmp_result", out_result, m_result);
        check("cmp_illegal", out_illegal, m_illegal);
        check("cmp_zero", out_zero, m_result == '0);
      end
    end
  end

  // Driver: present an op at a falling edge, return at the falling edge after accept.
  task automatic issue(input logic [1:0] aop, input logic [10:0] opc, input logic [5:0] sh,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n = 0;
    alu_op = aop; opcode = opc; shamt = sh; op_a = a; op_b = b; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) check("issue_timeout", 1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]    aop;
    logic [10:0]   opc;
    logic [DW-1:0] exp;
  } sweep_t;

  initial begin
    sweep_t sw[8];
    logic [DW-1:0] res, held;
    logic ill, mul, setf;
    logic [3:0] nz;
    int n;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; opcode = '0; shamt = '0; op_a = '0; op_b = '0;
    q4_in_valid = 1'b0; q4_out_ready = 1'b1; q4_alu_op = 2'b10;
    q4_opcode = O_MUL; q4_shamt = '0; q4_op_a = '0; q4_op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, '0);
    check("rst_out_illegal", out_illegal, 1'b0);
    check("rst_flags", flags_nzcv, 4'b0000);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    @(negedge clk);

    // Decode sweep, A=0x0F B=0x03 shamt=2.
    sw[0] = '{2'b10, O_ADD, 64'h12};
    sw[1] = '{2'b10, O_SUB, 64'h0C};
    sw[2] = '{2'b10, O_AND, 64'h03};
    sw[3] = '{2'b10, O_ORR, 64'h0F};
    sw[4] = '{2'b10, O_EOR, 64'h0C};
    sw[5] = '{2'b10, O_LSL, 64'h3C};
    sw[6] = '{2'b10, O_LSR, 64'h03};
    sw[7] = '{2'b01, O_ADD, 64'h03};
    for (int i = 0; i < 8; i++) begin
      ref_exec(sw[i].aop, sw[i].opc, 6'd2, 64'h0F, 64'h03, res, ill, mul, setf, nz);
      check($sformatf("model_sweep_%0d", i), res, sw[i].exp);
      issue(sw[i].aop, sw[i].opc, 6'd2, 64'h0F, 64'h03);
      check($sformatf("sweep_valid_%0d", i), out_valid, 1'b1);
      check($sformatf("sweep_result_%0d", i), out_result, sw[i].exp);
      check($sformatf("sweep_illegal_%0d", i), out_illegal, 1'b0);
    end

    // Flags.
    issue(2'b10, O_SUBS, 6'd0, 64'd5, 64'd5);
    check("subs_result", out_result, 64'd0);
    check("subs_zero", out_zero, 1'b1);
    check("subs_flags", flags_nzcv, 4'b0110);
    issue(2'b10, O_ADDS, 6'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    check("adds_result", out_result, 64'h8000_0000_0000_0000);
    check("adds_flags", flags_nzcv, 4'b1001);
    issue(2'b10, O_ADD, 6'd0, 64'd1, 64'd1);
    check("add_keeps_flags", flags_nzcv, 4'b1001);
    issue(2'b10, 11'b11111111111, 6'd2, 64'h0F, 64'h03);
    check("illegal_result", out_result, 64'd0);
    check("illegal_flag", out_illegal, 1'b1);
    check("illegal_keeps_flags", flags_nzcv, 4'b1001);
    issue(2'b11, O_ADD, 6'd0, 64'h0F, 64'h03);
    check("rsvd_illegal", out_illegal, 1'b1);

    // MUL with one multiplier bit per cycle; inputs wiggle during iteration.
    issue(2'b10, O_MUL, 6'd0, 64'd7, 64'd6);
    for (int i = 0; i < MUL_N; i++) begin
      if (i > 0) @(negedge clk);
      check("mul1_busy", busy, 1'b1);
      check("mul1_in_ready", in_ready, 1'b0);
      in_valid = (i < MUL_N - 1);
      alu_op = 2'b00; op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
    end
    @(negedge clk);
    check("mul1_done_busy", busy, 1'b0);
    check("mul1_valid", out_valid, 1'b1);
    check("mul1_result", out_result, 64'd42);

    // MUL with four multiplier bits per cycle on the second instance.
    q4_op_a = 64'd7; q4_op_b = 64'd6; q4_in_valid = 1'b1;
    #1;
    check("mul4_ready", q4_in_ready, 1'b1);
    @(posedge clk); #1;
    q4_in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("mul4_busy", q4_busy, 1'b1);
      q4_op_a = {$urandom, $urandom};
    end
    @(negedge clk);
    check("mul4_done_busy", q4_busy, 1'b0);
    check("mul4_valid", q4_out_valid, 1'b1);
    check("mul4_result", q4_out_result, 64'd42);

    // Backpressure, then same-edge consume and accept.
    issue(2'b00, O_ADD, 6'd0, 64'd10, 64'd20);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_valid", out_valid, 1'b1);
      check("bp_result_held", out_result, 64'd30);
    end
    alu_op = 2'b00; op_a = 64'd1; op_b = 64'd2; in_valid = 1'b1;
    @(negedge clk);
    check("bp_still_held", out_result, 64'd30);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_replace_valid", out_valid, 1'b1);
    check("bp_replace_result", out_result, 64'd3);

    // Reset during MUL iteration.
    issue(2'b10, O_MUL, 6'd0, 64'd3, 64'd5);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mulrst_busy", busy, 1'b0);
    check("mulrst_valid", out_valid, 1'b0);
    check("mulrst_flags", flags_nzcv, 4'b0000);
    reset_n = 1'b1;
    issue(2'b00, O_ADD, 6'd0, 64'd100, 64'd23);
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_result", out_result, 64'd123);

    // Throughput: eight back-to-back ADDs, in-order results.
    out_ready = 1'b1; alu_op = 2'b00; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
      exp_q.push_back(op_a + op_b);
      @(negedge clk);
      check("tput_valid", out_valid, 1'b1);
      check("tput_result", out_result, exp_q.pop_front());
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Randomized traffic; the compare process checks every cycle.
    for (int cyc = 0; cyc < 600; cyc++) begin
      int r, idx;
      r = $urandom_range(0, 19);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      alu_op = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r == 4) ? 2'b11 : 2'b10;
      idx = $urandom_range(0, 11);
      opcode = (idx == 11) ? 11'($urandom) : OPC_TAB[idx];
      if (opcode == O_MUL && $urandom_range(0, 7) != 0) opcode = O_SUBS;
      shamt = 6'($urandom);
      op_a = {$urandom, $urandom};
      op_b = ($urandom_range(0, 5) == 0) ? op_a : {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) op_a = 64'h7FFF_FFFF_FFFF_FFFF;
      @(negedge clk);
    end

    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) check("drain_timeout", 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised successor to the combinational ALU-control decoder. It merges ALU-op/opcode decode with a registered execute stage for the LEGv8 pipeline. It extends the op set with S-variants, EOR, LSL/LSR and an iterative multi-cycle MUL, and adds a persistent NZCV flag register. Valid/ready handshakes on both sides let the EX stage stall cleanly during MUL.

Parameters:
DATA_W, 64, operand/result width; must be a power of two, at least 8.
MUL_BITS, 1, multiplier bits retired per cycle; must divide DATA_W.
SHAMT_W, $clog2(DATA_W), shift-amount width.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous, active-low reset
in_valid  in  1  operation presented
in_ready  out  1  unit accepts operation this cycle
alu_op  in  2  00 = add (load/store address), 01 = pass B (CBZ), 10 = decode opcode, 11 = reserved
opcode  in  11  instruction[31:21]
shamt  in  SHAMT_W  shift amount for LSL/LSR
op_a  in  DATA_W  operand A
op_b  in  DATA_W  operand B
out_valid  out  1  result register holds valid data
out_ready  in  1  downstream consumes result
out_result  out  DATA_W  registered result
out_zero  out  1  out_result == 0 (combinational from result register)
out_illegal  out  1  registered; op was undecodable
flags_nzcv  out  4  architectural flag register {N,Z,C,V}
busy  out  1  MUL iteration in progress

Behaviour:
- Reset (reset_n low at a clk edge):
  - out_valid=0, out_result=0, out_illegal=0, flags_nzcv=0, busy=0.
  - Any in-flight MUL is aborted with no output.
- Decode, internal 4-bit ctl code:
  - alu_op 00 -> ADD 0010; 01 -> PASSB 0111; 11 -> ctl 0000 with illegal=1.
  - alu_op 10 decodes opcode: ADD 10001011000 -> 0010; SUB 11001011000 -> 0110; AND 10001010000 -> 0000; ORR 10101010000 -> 0001; EOR 11001010000 -> 0011; LSL 11010011011 -> 0100; LSR 11010011010 -> 0101; MUL 10011011000 -> 1000.
  - S-variants set flags: ADDS 10101011000 (add), SUBS 11101011000 (sub), ANDS 11101010000 (and).
  - Any other opcode -> ctl 0000, illegal=1, no flag write.
- in_ready = !busy && (!out_valid || out_ready).
- An op is accepted on an edge where in_valid && in_ready.
- Single-cycle ops:
  - The result is loaded at the accept edge; out_valid=1 the following cycle (latency 1).
  - Back-to-back throughput is 1 per cycle while out_ready=1.
- MUL:
  - At the accept edge busy becomes 1 and the operands are latched. Shift-add runs for N = DATA_W/MUL_BITS cycles.
  - The low DATA_W bits of the product are loaded at the N-th edge after acceptance; busy clears at the same edge and out_valid=1.
  - in_ready=0 throughout. Input changes during iteration are ignored.
  - Operand changes during iteration do not affect the result.
- Output hold: out_valid stays 1 and out_result stays stable until out_valid && out_ready.
- When the output is consumed and no new result loads at the same edge, out_valid drops.
- Simultaneous consume and accept: the new result replaces the old; out_valid stays 1.
- Arithmetic rules:
  - Add/sub are modulo 2^DATA_W. SUB computes A + ~B + 1.
  - C is the carry-out (for SUB, C=1 means no borrow). V is signed overflow.
  - Shifts use shamt (range 0..DATA_W-1); LSR is logical, zero-filled. PASSB outputs op_b.
- Flags:
  - Written only at the edge where an S-variant result loads: N = result[DATA_W-1], Z = (result==0).
  - C/V as above for ADDS/SUBS; for ANDS, C=0 and V=0.
  - Non-S ops and illegal ops leave flags unchanged.
- out_illegal: loaded with each result, with out_result=0 for illegal ops.

Decomposition:
- Shared package alu_exec_pkg holds:
  - the 11-bit opcode constants,
  - the 4-bit ctl-code constants,
  - the alu_op encodings,
  - a NZCV index typedef.
- One sub-module, alu_mul_iter:
  - inputs: start, a, b; outputs: busy, done, product.
  - parametrised by DATA_W and MUL_BITS.
  - honours the same synchronous reset_n.

Test Plan:
- Decode sweep: alu_op=10 with each listed opcode, A=0x0F, B=0x03, shamt=2, out_ready=1 -> one cycle later:
  - ADD 0x12, SUB 0x0C, AND 0x03, ORR 0x0F, EOR 0x0C, LSL 0x3C, LSR 0x03, and alu_op=01 -> 0x03.
  - Opcode 11111111111 -> result 0, out_illegal=1, flags unchanged.
- Flags: SUBS A=5, B=5 -> result 0, NZCV=0110.
  - ADDS A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> NZCV=1001.
  - Following plain ADD -> flags still 1001.
- MUL with DATA_W=64, MUL_BITS=1: A=7, B=6 accepted at edge T -> busy=1 and in_ready=0 for 64 cycles; out_result=42 valid after edge T+64.
  - Repeat with MUL_BITS=4 -> valid after T+16.
- Backpressure: out_ready=0 after an ADD result -> in_ready=0, result held for 5 cycles.
  - Raise out_ready with a new op waiting -> same-edge replace, out_valid stays 1, no bubble.
- Reset mid-MUL: reset_n low at cycle 10 of 64 -> next cycle busy=0, out_valid=0, flags=0.
  - A new ADD accepted right after reset_n returns high completes normally.
- Throughput: 8 back-to-back ADDs with out_ready=1 -> 8 consecutive out_valid cycles with correct, in-order results.
